// File: rtl/prog_load_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_load_pkg;

    typedef enum logic [2:0] {
        HDR_I,
        LOAD_I,
        WR_I,
        HDR_D,
        LOAD_D,
        WR_D,
        DONE,
        ERR
    } state_t;

    localparam logic [31:0] NOP_INSN  = 32'h00000013;
    localparam int unsigned HDR_BYTES = 4;

endpackage

// File: rtl/prog_load_asm.sv
// Little-endian byte-to-word assembler: four accepted bytes form one 32-bit word.
module prog_load_asm
    import prog_load_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        take,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam logic [1:0] LAST_BYTE = 2'(HDR_BYTES - 1);

    logic [1:0]  cnt;
    logic [23:0] sr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            sr  <= '0;
        end else if (take) begin
            cnt <= cnt + 2'd1;
            sr  <= {byte_data, sr[23:8]};
        end
    end

    // The word completes combinationally with its 4th byte so the FSM can act that cycle.
    assign word_valid = take && (cnt == LAST_BYTE);
    assign word       = {byte_data, sr};

endmodule

// File: rtl/prog_load_ctrl.sv
// Boot-time program loader: parses NI/insn/ND/data stream and drives imem/dmem load ports.
module prog_load_ctrl
    import prog_load_pkg::*;
#(
    parameter int unsigned IMEM_LINES = 512,
    parameter int unsigned DMEM_WORDS = 4096
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    output logic         rx_ready,
    output logic         prog_loading,
    output logic [31:0]  prog_loadaddr,
    output logic [127:0] prog_loaddata,
    output logic         prog_imem_we,
    output logic         prog_dmem_we,
    output logic         done,
    output logic         err
);

    localparam logic [31:0] IMEM_CAP = 32'(4 * IMEM_LINES);
    localparam logic [31:0] DMEM_CAP = 32'(DMEM_WORDS);

    state_t state, state_next;

    logic [31:0]  ni, nd, insn_cnt, line, word_cnt, dword;
    logic [31:0]  word;
    logic [127:0] line_buf;
    logic         take, word_valid, last_insn;

    // rx_ready depends on state only, keeping the assembler handshake loop-free.
    assign rx_ready  = state inside {HDR_I, LOAD_I, HDR_D, LOAD_D};
    assign take      = rx_valid & rx_ready;
    assign last_insn = (insn_cnt[1:0] == 2'd3) || (insn_cnt + 32'd1 == ni);

    prog_load_asm u_asm (
        .clk        (clk),
        .reset      (reset),
        .take       (take),
        .byte_data  (rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= HDR_I;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        prog_loading  = 1'b1;
        prog_loadaddr = '0;
        prog_loaddata = '0;
        prog_imem_we  = 1'b0;
        prog_dmem_we  = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        case (state)
            HDR_I: if (word_valid) begin
                if (word > IMEM_CAP)  state_next = ERR;
                else if (word == '0)  state_next = HDR_D;
                else                  state_next = LOAD_I;
            end
            LOAD_I: if (word_valid && last_insn) state_next = WR_I;
            WR_I: begin
                prog_imem_we  = 1'b1;
                prog_loadaddr = line << 4;
                prog_loaddata = line_buf;
                state_next    = (insn_cnt == ni) ? HDR_D : LOAD_I;
            end
            HDR_D: if (word_valid) begin
                if (word > DMEM_CAP)  state_next = ERR;
                else if (word == '0)  state_next = DONE;
                else                  state_next = LOAD_D;
            end
            LOAD_D: if (word_valid) state_next = WR_D;
            WR_D: begin
                prog_dmem_we  = 1'b1;
                prog_loadaddr = word_cnt << 2;
                prog_loaddata = {dword, 96'h0};
                state_next    = (word_cnt + 32'd1 == nd) ? DONE : LOAD_D;
            end
            DONE: begin
                prog_loading = 1'b0;
                done         = 1'b1;
            end
            ERR: err = 1'b1;
            default: state_next = HDR_I;
        endcase
    end

    // Line buffer refills with NOPs so a short final line is padded without extra logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ni       <= '0;
            nd       <= '0;
            insn_cnt <= '0;
            line     <= '0;
            word_cnt <= '0;
            dword    <= '0;
            line_buf <= {4{NOP_INSN}};
        end else begin
            case (state)
                HDR_I: if (word_valid) ni <= word;
                LOAD_I: if (word_valid) begin
                    case (insn_cnt[1:0])
                        2'd0: line_buf[127:96] <= word;
                        2'd1: line_buf[95:64]  <= word;
                        2'd2: line_buf[63:32]  <= word;
                        default: line_buf[31:0] <= word;
                    endcase
                    insn_cnt <= insn_cnt + 32'd1;
                end
                WR_I: begin
                    line     <= line + 32'd1;
                    line_buf <= {4{NOP_INSN}};
                end
                HDR_D: if (word_valid) nd <= word;
                LOAD_D: if (word_valid) dword <= word;
                WR_D: word_cnt <= word_cnt + 32'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Self-checking bench for prog_load_ctrl: image model builds the expected write list.
module tb_prog_load_ctrl;

    localparam logic [31:0] NOP = 32'h00000013;

    logic         clk = 1'b0;
    logic         reset;
    logic         rx_valid;
    logic [7:0]   rx_data;
    logic         rx_ready;
    logic         prog_loading;
    logic [31:0]  prog_loadaddr;
    logic [127:0] prog_loaddata;
    logic         prog_imem_we;
    logic         prog_dmem_we;
    logic         done;
    logic         err;

    always #5 clk = ~clk;

    prog_load_ctrl #(.IMEM_LINES(512), .DMEM_WORDS(4096)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready),
        .prog_loading  (prog_loading),
        .prog_loadaddr (prog_loadaddr),
        .prog_loaddata (prog_loaddata),
        .prog_imem_we  (prog_imem_we),
        .prog_dmem_we  (prog_dmem_we),
        .done          (done),
        .err           (err)
    );

    typedef struct {
        bit           imem;
        logic [31:0]  addr;
        logic [127:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         e;
    logic [31:0] insn_q[$];
    logic [31:0] data_q[$];
    logic [7:0]  byte_q[$];
    int          total = 0;
    int          bad   = 0;
    int          held  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic add_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) byte_q.push_back(w[8*i +: 8]);
    endtask

    // Image model: stream bytes plus the list of memory writes the image implies.
    task automatic build_image();
        int ni, nd, nl;
        logic [127:0] d;
        ni = insn_q.size();
        nd = data_q.size();
        byte_q.delete();
        add_word(32'(ni));
        foreach (insn_q[i]) add_word(insn_q[i]);
        add_word(32'(nd));
        foreach (data_q[i]) add_word(data_q[i]);
        nl = (ni + 3) / 4;
        for (int l = 0; l < nl; l++) begin
            for (int k = 0; k < 4; k++)
                d[127 - 32*k -: 32] = (4*l + k < ni) ? insn_q[4*l + k] : NOP;
            exp_q.push_back('{imem: 1'b1, addr: 32'(l * 16), data: d});
        end
        for (int j = 0; j < nd; j++)
            exp_q.push_back('{imem: 1'b0, addr: 32'(j * 4), data: {data_q[j], 96'h0}});
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        bit rdy;
        rx_valid = 1'b1;
        rx_data  = b;
        do begin
            rdy = rx_ready;
            if (!rdy) held++;
            @(posedge clk);
            @(negedge clk);
            waited++;
        end while (!rdy && waited < 100);
        if (!rdy) begin
            total++;
            bad++;
            $display("FAIL byte_stall: byte %h not accepted, rx_ready=%b", b, rx_ready);
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_stream(input bit gaps);
        foreach (byte_q[i]) begin
            send_byte(byte_q[i]);
            if (gaps && i != byte_q.size() - 1) repeat (i % 3) @(negedge clk);
        end
    endtask

    task automatic check_end(input int nd);
        if (nd != 0) begin
            chk("final_wr_loading", {127'h0, prog_loading}, 128'h1);
            chk("final_wr_done", {127'h0, done}, 128'h0);
            @(negedge clk);
        end
        chk("end_done", {127'h0, done}, 128'h1);
        chk("end_loading", {127'h0, prog_loading}, 128'h0);
        chk("end_rx_ready", {127'h0, rx_ready}, 128'h0);
        chk("end_err", {127'h0, err}, 128'h0);
        chk("queue_drained", 128'(exp_q.size()), 128'h0);
        repeat (3) @(negedge clk);
        chk("done_sticky", {127'h0, done}, 128'h1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_loading"}, {127'h0, prog_loading}, 128'h1);
        chk({tag, "_rx_ready"}, {127'h0, rx_ready}, 128'h1);
        chk({tag, "_strobes"}, {126'h0, prog_imem_we, prog_dmem_we}, 128'h0);
        chk({tag, "_flags"}, {126'h0, done, err}, 128'h0);
        chk({tag, "_addr"}, {96'h0, prog_loadaddr}, 128'h0);
        chk({tag, "_data"}, prog_loaddata, 128'h0);
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_reset_vals(tag);
        @(negedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        insn_q.delete();
        data_q.delete();
    endtask

    task automatic check_err_state(input string tag);
        chk({tag, "_err"}, {127'h0, err}, 128'h1);
        chk({tag, "_rx_ready"}, {127'h0, rx_ready}, 128'h0);
        chk({tag, "_loading"}, {127'h0, prog_loading}, 128'h1);
        chk({tag, "_done"}, {127'h0, done}, 128'h0);
        repeat (5) @(negedge clk);
        chk({tag, "_err_sticky"}, {126'h0, err, prog_loading}, 128'h3);
    endtask

    // Compare process: every write strobe is checked against the expected write list.
    always @(negedge clk) begin
        if (!reset && (prog_imem_we || prog_dmem_we)) begin
            chk("strobe_excl", {127'h0, prog_imem_we & prog_dmem_we}, 128'h0);
            chk("wr_rx_ready", {127'h0, rx_ready}, 128'h0);
            chk("wr_loading", {127'h0, prog_loading}, 128'h1);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: imem_we=%b dmem_we=%b addr=%h", prog_imem_we, prog_dmem_we, prog_loadaddr);
            end else begin
                e = exp_q.pop_front();
                chk("wr_kind", {127'h0, prog_imem_we}, {127'h0, e.imem});
                chk("wr_addr", {96'h0, prog_loadaddr}, {96'h0, e.addr});
                chk("wr_data", prog_loaddata, e.data);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        #1 reset = 1'b0;

        // 1: one full line, no data.
        insn_q = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004};
        build_image();
        chk("model_t1", exp_q[0].data, 128'hAAAA0001_BBBB0002_CCCC0003_DDDD0004);
        send_stream(1'b0);
        check_end(0);

        // 2: partial second line padded with NOP, two data words.
        do_reset("rst2");
        insn_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
        data_q = '{32'h0000BEEF, 32'hCAFE0000};
        build_image();
        chk("model_t2_line1", exp_q[1].data, 128'h55555555_00000013_00000013_00000013);
        chk("model_t2_addr1", {96'h0, exp_q[1].addr}, 128'h10);
        chk("model_t2_dmem1", exp_q[3].data, {32'hCAFE0000, 96'h0});
        send_stream(1'b0);
        check_end(2);

        // 3: byte order, raw stream and literal expectation.
        do_reset("rst3");
        byte_q = '{8'h02, 8'h00, 8'h00, 8'h00,
                   8'h13, 8'h00, 8'h00, 8'h00,
                   8'h78, 8'h56, 8'h34, 8'h12,
                   8'h00, 8'h00, 8'h00, 8'h00};
        exp_q.push_back('{imem: 1'b1, addr: 32'h0, data: 128'h00000013_12345678_00000013_00000013});
        send_stream(1'b0);
        check_end(0);

        // Empty image completes immediately after the two headers.
        do_reset("rst_empty");
        build_image();
        send_stream(1'b0);
        check_end(0);

        // 4: NI over capacity.
        do_reset("rst4");
        byte_q.delete();
        add_word(32'd2049);
        send_stream(1'b0);
        check_err_state("ni_over");

        // ND over capacity after an empty instruction section.
        do_reset("rst4b");
        byte_q.delete();
        add_word(32'd0);
        add_word(32'd4097);
        send_stream(1'b0);
        check_err_state("nd_over");

        // 5: valid gaps mid-word and bytes held across write cycles.
        do_reset("rst5");
        for (int i = 0; i < 7; i++) insn_q.push_back(32'h01020304 * (i + 1) + 32'hA0000000);
        data_q = '{32'h89ABCDEF, 32'h00000001, 32'hFFFFFFFF};
        build_image();
        held = 0;
        send_stream(1'b1);
        check_end(3);
        chk("held_seen", {127'h0, held > 0}, 128'h1);

        // 6: reset mid line 1, then reload from address 0.
        do_reset("rst6a");
        insn_q = '{32'h10000001, 32'h20000002, 32'h30000003, 32'h40000004, 32'h50000005};
        build_image();
        for (int i = 0; i < 22; i++) send_byte(byte_q[i]);
        chk("line0_written", 128'(exp_q.size()), 128'h1);
        do_reset("rst6b");
        insn_q = '{32'hDEAD0000, 32'hBEEF1111, 32'hF00D2222, 32'h0BAD3333};
        build_image();
        send_stream(1'b0);
        check_end(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
